// File: rtl/cr_compressor.sv
// RV32I -> RV32C compressor for CR-format ops (c.jr/c.jalr/c.mv/c.add), packing a
// mixed 16/32-bit stream into 32-bit words. Optional: CR_COMMUTE_EN (commuted c.add).
module cr_compressor (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iVALID,
  input  logic [31:0] iINSTR,
  input  logic        iFLUSH,
  output logic        oREADY,
  output logic        oVALID,
  output logic [31:0] oWORD,
  input  logic        iREADY,
  output logic [7:0]  oPC,
  output logic [15:0] oCNT_C,
  output logic        oIDLE
);

  typedef enum logic {S_EMPTY = 1'b0, S_HALF = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [15:0] pend_q, pend_d;
  logic        vld_q, vld_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;

  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        is32, comp, is16;
  logic [15:0] half;
  logic        accept, flush_go;

  assign opc = iINSTR[6:0];
  assign rd  = iINSTR[11:7];
  assign f3  = iINSTR[14:12];
  assign rs1 = iINSTR[19:15];
  assign rs2 = iINSTR[24:20];
  assign f7  = iINSTR[31:25];
  assign is32 = (iINSTR[1:0] == 2'b11);

  always_comb begin
    comp = 1'b0;
    half = iINSTR[15:0];
    if (is32) begin
      if (opc == 7'b1100111 && f3 == 3'b000 && iINSTR[31:20] == 12'd0 && rs1 != 5'd0) begin
        if (rd == 5'd0) begin
          comp = 1'b1;
          half = {4'b1000, rs1, 5'd0, 2'b10};
        end else if (rd == 5'd1) begin
          comp = 1'b1;
          half = {4'b1001, rs1, 5'd0, 2'b10};
        end
      end else if (opc == 7'b0110011 && f3 == 3'b000 && f7 == 7'd0 &&
                   rd != 5'd0 && rs2 != 5'd0) begin
        if (rs1 == 5'd0) begin
          comp = 1'b1;
          half = {4'b1000, rd, rs2, 2'b10};
        end else if (rs1 == rd) begin
          comp = 1'b1;
          half = {4'b1001, rd, rs2, 2'b10};
        end
`ifdef CR_COMMUTE_EN
        else if (rs2 == rd) begin
          // add is commutative: rd = rs1 + rd fits c.add with rs1 as the source
          comp = 1'b1;
          half = {4'b1001, rd, rs1, 2'b10};
        end
`endif
      end
    end
  end

  assign is16     = !is32 || comp;
  assign oREADY   = !vld_q || iREADY;
  assign accept   = iVALID && oREADY;
  assign flush_go = iFLUSH && !iVALID && oREADY && (state_q == S_HALF);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    word_d  = word_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    // a completed transfer with nothing new drops valid; otherwise hold
    vld_d   = vld_q && !iREADY;
    if (accept) begin
      pc_d = pc_q + (is16 ? 8'd2 : 8'd4);
      if (comp) cnt_d = cnt_q + 16'd1;
      case (state_q)
        S_EMPTY: begin
          if (is16) begin
            state_d = S_HALF;
            pend_d  = half;
          end else begin
            vld_d  = 1'b1;
            word_d = iINSTR;
          end
        end
        S_HALF: begin
          vld_d = 1'b1;
          if (is16) begin
            word_d  = {half, pend_q};
            state_d = S_EMPTY;
          end else begin
            word_d = {iINSTR[15:0], pend_q};
            pend_d = iINSTR[31:16];
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end else if (flush_go) begin
      vld_d   = 1'b1;
      word_d  = {16'h0001, pend_q};
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_EMPTY;
      pend_q  <= 16'd0;
      vld_q   <= 1'b0;
      word_q  <= 32'd0;
      pc_q    <= 8'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      vld_q   <= vld_d;
      word_q  <= word_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oVALID = vld_q;
  assign oWORD  = word_q;
  assign oPC    = pc_q;
  assign oCNT_C = cnt_q;
  assign oIDLE  = (state_q == S_EMPTY) && !vld_q;

endmodule

// File: tb/tb_cr_compressor.sv
// Directed bench for cr_compressor: CR re-encoding, packing, flush, backpressure, reset.
module tb_cr_compressor;
  logic        iCLK, iRST_N, iVALID, iFLUSH, iREADY;
  logic [31:0] iINSTR;
  logic        oREADY, oVALID, oIDLE;
  logic [31:0] oWORD;
  logic [7:0]  oPC;
  logic [15:0] oCNT_C;

  int tests = 0;
  int fails = 0;

  cr_compressor dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iVALID(iVALID), .iINSTR(iINSTR), .iFLUSH(iFLUSH),
    .oREADY(oREADY), .oVALID(oVALID), .oWORD(oWORD), .iREADY(iREADY),
    .oPC(oPC), .oCNT_C(oCNT_C), .oIDLE(oIDLE)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Called at a negedge; returns at the next negedge after one posedge.
  task automatic put(input logic [31:0] ins);
    iVALID = 1'b1;
    iINSTR = ins;
    @(negedge iCLK);
    iVALID = 1'b0;
    iINSTR = 32'd0;
  endtask

  task automatic flush_cycle();
    iFLUSH = 1'b1;
    @(negedge iCLK);
    iFLUSH = 1'b0;
  endtask

  task automatic do_reset();
    iRST_N = 1'b0;
    @(negedge iCLK);
    iRST_N = 1'b1;
    @(negedge iCLK);
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    #1;
    tests++;
    if ({oVALID, oREADY, oIDLE} !== 3'b011 || oWORD !== 32'd0 || oPC !== 8'd0 || oCNT_C !== 16'd0) begin
      fails++;
      $display("FAIL reset: v/r/i=%b%b%b word=%h pc=%0d cnt=%0d, want 011 0 0 0",
               oVALID, oREADY, oIDLE, oWORD, oPC, oCNT_C);
    end
    @(negedge iCLK);
    iRST_N = 1'b1;
    @(negedge iCLK);
  endtask

  task automatic test_cjr();
    do_reset();
    put(32'h00028067);
    tests++;
    if (oVALID !== 1'b0 || oIDLE !== 1'b0) begin
      fails++;
      $display("FAIL cjr_half: oVALID=%b oIDLE=%b, want 0 0", oVALID, oIDLE);
    end
    put(32'h000280E7);
    tests++;
    if (oVALID !== 1'b1 || oWORD !== 32'h92828282) begin
      fails++;
      $display("FAIL cjr_word: oVALID=%b oWORD=%h, want 1 92828282", oVALID, oWORD);
    end
    tests++;
    if (oCNT_C !== 16'd2 || oPC !== 8'd4) begin
      fails++;
      $display("FAIL cjr_cnt_pc: cnt=%0d pc=%0d, want 2 4", oCNT_C, oPC);
    end
    @(negedge iCLK);
    tests++;
    if (oVALID !== 1'b0 || oIDLE !== 1'b1) begin
      fails++;
      $display("FAIL cjr_drain: oVALID=%b oIDLE=%b, want 0 1", oVALID, oIDLE);
    end
  endtask

  task automatic test_mv_add();
    do_reset();
    put(32'h00B00533);
    put(32'h00B50533);
    tests++;
    if (oVALID !== 1'b1 || oWORD !== 32'h952E852E || oCNT_C !== 16'd2) begin
      fails++;
      $display("FAIL mv_add: v=%b word=%h cnt=%0d, want 1 952e852e 2", oVALID, oWORD, oCNT_C);
    end
  endtask

  task automatic test_nocomp();
    logic [31:0] vec [3];
    vec[0] = 32'h00000067;
    vec[1] = 32'h00428067;
    vec[2] = 32'h00B00033;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      put(vec[i]);
      tests++;
      if (oVALID !== 1'b1 || oWORD !== vec[i] || oCNT_C !== 16'd0 || oPC !== 8'(4 * (i + 1))) begin
        fails++;
        $display("FAIL nocomp[%0d]: v=%b word=%h cnt=%0d pc=%0d, want 1 %h 0 %0d",
                 i, oVALID, oWORD, oCNT_C, oPC, vec[i], 4 * (i + 1));
      end
    end
  endtask

  task automatic test_straddle_flush();
    do_reset();
    put(32'h00028067);
    put(32'h00100093);
    tests++;
    if (oVALID !== 1'b1 || oWORD !== 32'h00938282) begin
      fails++;
      $display("FAIL straddle: v=%b word=%h, want 1 00938282", oVALID, oWORD);
    end
    flush_cycle();
    tests++;
    if (oVALID !== 1'b1 || oWORD !== 32'h00010010 || oPC !== 8'd6) begin
      fails++;
      $display("FAIL flush_half: v=%b word=%h pc=%0d, want 1 00010010 6", oVALID, oWORD, oPC);
    end
    @(negedge iCLK);
    tests++;
    if (oIDLE !== 1'b1 || oVALID !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle: idle=%b v=%b, want 1 0", oIDLE, oVALID);
    end
    flush_cycle();
    tests++;
    if (oVALID !== 1'b0 || oIDLE !== 1'b1 || oPC !== 8'd6) begin
      fails++;
      $display("FAIL flush_empty: v=%b idle=%b pc=%0d, want 0 1 6", oVALID, oIDLE, oPC);
    end
    // flush coincident with a valid instruction is ignored
    do_reset();
    iFLUSH = 1'b1;
    put(32'h00000001);
    iFLUSH = 1'b0;
    tests++;
    if (oVALID !== 1'b0 || oIDLE !== 1'b0 || oPC !== 8'd2 || oCNT_C !== 16'd0) begin
      fails++;
      $display("FAIL flush_with_valid: v=%b idle=%b pc=%0d cnt=%0d, want 0 0 2 0",
               oVALID, oIDLE, oPC, oCNT_C);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    iREADY = 1'b0;
    put(32'h00000067);
    iVALID = 1'b1;
    iINSTR = 32'h00428067;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (oVALID !== 1'b1 || oWORD !== 32'h00000067 || oREADY !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: v=%b word=%h rdy=%b, want 1 00000067 0",
                 i, oVALID, oWORD, oREADY);
      end
      @(negedge iCLK);
    end
    iREADY = 1'b1;
    @(negedge iCLK);
    iVALID = 1'b0;
    iINSTR = 32'd0;
    tests++;
    if (oVALID !== 1'b1 || oWORD !== 32'h00428067 || oPC !== 8'd8) begin
      fails++;
      $display("FAIL bp_release: v=%b word=%h pc=%0d, want 1 00428067 8", oVALID, oWORD, oPC);
    end
    put(32'h00028067);
    tests++;
    if (oIDLE !== 1'b0 || oVALID !== 1'b0) begin
      fails++;
      $display("FAIL bp_half: idle=%b v=%b, want 0 0", oIDLE, oVALID);
    end
    #2;
    iRST_N = 1'b0;
    #1;
    tests++;
    if ({oVALID, oREADY, oIDLE} !== 3'b011 || oWORD !== 32'd0 || oPC !== 8'd0 || oCNT_C !== 16'd0) begin
      fails++;
      $display("FAIL midreset: v/r/i=%b%b%b word=%h pc=%0d cnt=%0d, want 011 0 0 0",
               oVALID, oREADY, oIDLE, oWORD, oPC, oCNT_C);
    end
    @(negedge iCLK);
    iRST_N = 1'b1;
    @(negedge iCLK);
  endtask

  task automatic test_commute();
    logic [31:0] exp_w;
    logic [15:0] exp_c;
    do_reset();
    put(32'h00A58533);
`ifdef CR_COMMUTE_EN
    flush_cycle();
    exp_w = 32'h0001952E;
    exp_c = 16'd1;
`else
    exp_w = 32'h00A58533;
    exp_c = 16'd0;
`endif
    tests++;
    if (oVALID !== 1'b1 || oWORD !== exp_w || oCNT_C !== exp_c) begin
      fails++;
      $display("FAIL commute: v=%b word=%h cnt=%0d, want 1 %h %0d", oVALID, oWORD, oCNT_C, exp_w, exp_c);
    end
  endtask

  initial begin
    iRST_N = 1'b0;
    iVALID = 1'b0;
    iINSTR = 32'd0;
    iFLUSH = 1'b0;
    iREADY = 1'b1;
    @(negedge iCLK);
    test_reset();
    test_cjr();
    test_mv_add();
    test_nocomp();
    test_straddle_flush();
    test_backpressure();
    test_commute();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cr_compressor.md
# cr_compressor

Streaming RV32I-to-RV32C compressor for the CR format, the encode-side counterpart of the CR decode path. Accepts one 32-bit instruction per handshake, re-encodes it as c.jr, c.jalr, c.mv or c.add when legal, otherwise passes it through unchanged. Packs the mixed 16/32-bit result little-endian into a 32-bit word stream for the instruction memory image builder.

## Interface
- Parameters: none.
- iCLK  in  1  clock, all state on rising edge.
- iRST_N  in  1  asynchronous, active-low reset.
- iVALID  in  1  input instruction valid.
- iINSTR  in  32  instruction. If [1:0] != 2'b11, already compressed; [15:0] is used.
- iFLUSH  in  1  emit the pending halfword padded with c.nop.
- oREADY  out  1  input accepted when iVALID && oREADY.
- oVALID  out  1  oWORD valid.
- oWORD  out  32  packed word; lower halfword is earlier in program order.
- iREADY  in  1  downstream accepts oWORD when oVALID && iREADY.
- oPC  out  8  byte offset of the next accepted instruction in the compressed stream.
- oCNT_C  out  16  count of instructions re-encoded to 16 bits.
- oIDLE  out  1  no pending halfword and no output held.

## Operation
- Compressible when all of the following hold (otherwise emitted as 32-bit):
  - jalr (opcode 1100111, funct3 000, imm 0, rs1 != 0): rd = x0 -> c.jr = {4'b1000, rs1, 5'b0, 2'b10}; rd = x1 -> c.jalr = {4'b1001, rs1, 5'b0, 2'b10}.
  - add (opcode 0110011, funct3 000, funct7 0, rd != 0, rs2 != 0): rs1 = x0 -> c.mv = {4'b1000, rd, rs2, 2'b10}; rs1 = rd -> c.add = {4'b1001, rd, rs2, 2'b10}.
- c.mv takes priority over c.add; the two never overlap because rd != 0.
- Input with [1:0] != 2'b11 passes through as 16 bits and is not counted in oCNT_C.
- State machine EMPTY (no pending halfword) / HALF (register PEND holds one halfword):
  - EMPTY + 16-bit -> HALF, PEND = half.
  - EMPTY + 32-bit -> emit iINSTR, stay EMPTY.
  - HALF + 16-bit -> emit {half, PEND} -> EMPTY.
  - HALF + 32-bit -> emit {iINSTR[15:0], PEND}, PEND = iINSTR[31:16], stay HALF.
- Flush: honored only when iFLUSH && !iVALID && oREADY.
  - HALF: emit {16'h0001, PEND} -> EMPTY.
  - EMPTY: no-op.
  - iFLUSH with iVALID high: the instruction is taken and the flush is ignored that cycle.
- oPC advances by 2 (16-bit) or 4 (32-bit) per accepted instruction and wraps modulo 256. A flush pad does not advance oPC.
- oCNT_C wraps at 16'hFFFF -> 0.
- oIDLE = (state == EMPTY) && !oVALID.

## Timing
- Reset (async assert, sync-to-clock release) clears all state to the following values:
  - state EMPTY, PEND 0;
  - oVALID 0, oWORD 0;
  - oPC 0, oCNT_C 0;
  - oREADY 1, oIDLE 1.
- oREADY = !oVALID || iREADY (combinational); this is the single rule for all states.
- Output is registered. A word produced by an accept in cycle N shows oVALID = 1 at cycle N+1.
- While oVALID && !iREADY, oWORD and oVALID hold stable and no input is accepted.
- With iREADY high, the block sustains one accepted instruction per cycle.
- If a transfer completes and a new word is produced in the same cycle, oVALID stays 1 and oWORD updates.
- If a transfer completes with no new word, oVALID drops to 0 the next cycle.
- Reset mid-operation discards PEND and any held oWORD without emitting them.

## Configuration
- CR_COMMUTE_EN defined: add with rs2 == rd, rs1 != 0, rs1 != rd, rd != 0 also compresses, to c.add {4'b1001, rd, rs1, 2'b10}.
- CR_COMMUTE_EN undefined: such adds are emitted as 32-bit.

## Test plan
- c.jr stream: 0x00028067 then 0x000280E7, iREADY = 1 -> oWORD = 0x92828282 one cycle after the second accept; oCNT_C = 2, oPC = 4.
- c.mv/c.add: 0x00B00533, 0x00B50533 -> oWORD = 0x952E852E.
- Non-compressible cases: 0x00000067 (rs1 = 0), 0x00428067 (imm 4), 0x00B00033 (rd = 0) -> each emitted whole, oCNT_C unchanged, oPC advances by 4 each.
- Straddle and flush: 0x00028067, then 0x00100093, then a flush cycle -> words 0x00938282 and 0x00010010; oPC = 6; oIDLE = 1 afterward.
- Backpressure: iREADY held 0 for 5 cycles with oVALID = 1 -> oWORD stable and oREADY = 0 throughout; after release, the next word follows with no loss; then assert iRST_N = 0 while HALF -> all outputs at reset values immediately.
- Macro: 0x00A58533 -> 0x952E as a halfword with CR_COMMUTE_EN defined; emitted as 32-bit 0x00A58533 without it.
